// File: rtl/alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl
// Command sequencer and accumulator controller for the ALU datapath.
// Accepts one opcode/operand command per valid/ready handshake and applies it
// to the internal accumulator. Logic and add/sub ops finish at the accept
// edge; MULT and DIV run WIDTH iterations (shift-add / restoring divide).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   cmd_valid  command present
//   cmd_ready  controller idle, command can be accepted this cycle
//   opcode     4-bit command code
//   operand    B operand (A is always the accumulator)
//   acc        accumulator
//   rem        remainder of the last successful DIV
//   carry      ADD carry-out / SUB borrow / MULT overflow
//   zero       acc == 0 after the last acc-writing op
//   err        last command was illegal or divide-by-zero
//   done       one-cycle completion pulse
// -----------------------------------------------------------------------------
module alu_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] rem,
    output logic             carry,
    output logic             zero,
    output logic             err,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    localparam logic [3:0] OP_NOOP  = 4'b0000;
    localparam logic [3:0] OP_RESET = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0011;
    localparam logic [3:0] OP_MULT  = 4'b0100;
    localparam logic [3:0] OP_DIV   = 4'b0101;
    localparam logic [3:0] OP_AND   = 4'b0110;
    localparam logic [3:0] OP_OR    = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1000;
    localparam logic [3:0] OP_XOR   = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    function automatic logic is_zero(input logic [WIDTH-1:0] v);
        return (v == {WIDTH{1'b0}});
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    // Shared iteration registers: hi/lo form the 2*WIDTH working value
    // (product for MULT, remainder:dividend/quotient for DIV); opb holds the
    // multiplicand or divisor.
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;

    logic [WIDTH:0]   add_sum_s;
    logic [WIDTH-1:0] mul_addend_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH-1:0] mul_hi_s;
    logic [WIDTH-1:0] mul_lo_s;
    logic [WIDTH:0]   div_trial_s;
    logic [WIDTH:0]   div_diff_s;
    logic             div_fits_s;
    logic [WIDTH-1:0] div_r_s;
    logic [WIDTH-1:0] div_q_s;

    // Arithmetic for one ADD and one MULT/DIV iteration step.
    always_comb begin
        add_sum_s    = {1'b0, acc_q} + {1'b0, operand};

        // Shift-add: add multiplicand into the upper half when the current
        // multiplier LSB is set, then shift the whole product right by one.
        mul_addend_s = lo_q[0] ? opb_q : {WIDTH{1'b0}};
        mul_sum_s    = {1'b0, hi_q} + {1'b0, mul_addend_s};
        mul_hi_s     = mul_sum_s[WIDTH:1];
        mul_lo_s     = {mul_sum_s[0], lo_q[WIDTH-1:1]};

        // Restoring divide: shift the next dividend bit into the partial
        // remainder and subtract the divisor only if it fits.
        div_trial_s  = {hi_q, lo_q[WIDTH-1]};
        div_diff_s   = div_trial_s - {1'b0, opb_q};
        if (div_trial_s >= {1'b0, opb_q}) begin
            div_fits_s = 1'b1;
            div_r_s    = div_diff_s[WIDTH-1:0];
        end else begin
            div_fits_s = 1'b0;
            div_r_s    = div_trial_s[WIDTH-1:0];
        end
        div_q_s      = {lo_q[WIDTH-2:0], div_fits_s};
    end

    // Next-state and result logic for the sequencer FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        err_d   = err_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opb_d   = opb_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    done_d = 1'b1;
                    err_d  = 1'b0;
                    case (opcode)
                        OP_NOOP: begin
                            err_d = 1'b0;
                        end
                        OP_RESET: begin
                            acc_d   = {WIDTH{1'b0}};
                            rem_d   = {WIDTH{1'b0}};
                            carry_d = 1'b0;
                            zero_d  = 1'b1;
                        end
                        OP_ADD: begin
                            acc_d   = add_sum_s[WIDTH-1:0];
                            carry_d = add_sum_s[WIDTH];
                            zero_d  = is_zero(add_sum_s[WIDTH-1:0]);
                        end
                        OP_SUB: begin
                            acc_d   = acc_q - operand;
                            carry_d = (acc_q < operand);
                            zero_d  = is_zero(acc_q - operand);
                        end
                        OP_MULT: begin
                            done_d  = 1'b0;
                            state_d = ST_MUL;
                            cnt_d   = CNT_ZERO;
                            hi_d    = {WIDTH{1'b0}};
                            lo_d    = operand;
                            opb_d   = acc_q;
                        end
                        OP_DIV: begin
                            if (is_zero(operand)) begin
                                err_d = 1'b1;
                            end else begin
                                done_d  = 1'b0;
                                state_d = ST_DIV;
                                cnt_d   = CNT_ZERO;
                                hi_d    = {WIDTH{1'b0}};
                                lo_d    = acc_q;
                                opb_d   = operand;
                            end
                        end
                        OP_AND: begin
                            acc_d   = acc_q & operand;
                            carry_d = 1'b0;
                            zero_d  = is_zero(acc_q & operand);
                        end
                        OP_OR: begin
                            acc_d   = acc_q | operand;
                            carry_d = 1'b0;
                            zero_d  = is_zero(acc_q | operand);
                        end
                        OP_NOT: begin
                            acc_d   = ~acc_q;
                            carry_d = 1'b0;
                            zero_d  = is_zero(~acc_q);
                        end
                        OP_XOR: begin
                            acc_d   = acc_q ^ operand;
                            carry_d = 1'b0;
                            zero_d  = is_zero(acc_q ^ operand);
                        end
                        default: begin
                            err_d = 1'b1;
                        end
                    endcase
                end else begin
                    done_d = 1'b0;
                end
            end
            ST_MUL: begin
                hi_d = mul_hi_s;
                lo_d = mul_lo_s;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                    acc_d   = mul_lo_s;
                    carry_d = |mul_hi_s;
                    zero_d  = is_zero(mul_lo_s);
                    err_d   = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DIV: begin
                hi_d = div_r_s;
                lo_d = div_q_s;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                    acc_d   = div_q_s;
                    rem_d   = div_r_s;
                    carry_d = 1'b0;
                    zero_d  = is_zero(div_q_s);
                    err_d   = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            acc_q   <= {WIDTH{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
            opb_q   <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opb_q   <= opb_d;
        end
    end

    assign cmd_ready = ready_q;
    assign acc       = acc_q;
    assign rem       = rem_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign err       = err_q;
    assign done      = done_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_ctrl
// Directed bench for alu_seq_ctrl. A behavioural accumulator model computes
// the expected result of each accepted command and pushes it onto a
// scoreboard queue; the entry is popped and compared when done pulses.
// -----------------------------------------------------------------------------
module tb_alu_seq_ctrl;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   opcode;
    logic [W-1:0] operand;
    logic [W-1:0] acc;
    logic [W-1:0] rem;
    logic         carry;
    logic         zero;
    logic         err;
    logic         done;

    alu_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .opcode    (opcode),
        .operand   (operand),
        .acc       (acc),
        .rem       (rem),
        .carry     (carry),
        .zero      (zero),
        .err       (err),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] acc;
        logic [W-1:0] rem;
        logic         carry;
        logic         zero;
        logic         err;
        int           lat;
    } exp_t;

    exp_t sb[$];

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] m_acc;
    logic [W-1:0] m_rem;
    logic         m_carry;
    logic         m_zero;
    logic         m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_acc   = 16'h0000;
        m_rem   = 16'h0000;
        m_carry = 1'b0;
        m_zero  = 1'b1;
        m_err   = 1'b0;
        sb.delete();
    endtask

    // Apply one accepted command to the model and queue its expected result.
    task automatic model_push(input logic [3:0] op, input logic [W-1:0] b);
        exp_t        e;
        logic [16:0] s;
        logic [31:0] p;
        e.lat = 0;
        m_err = 1'b0;
        case (op)
            4'd0: ;
            4'd1: begin m_acc = 16'h0; m_rem = 16'h0; m_carry = 1'b0; m_zero = 1'b1; end
            4'd2: begin s = {1'b0, m_acc} + {1'b0, b}; m_acc = s[15:0]; m_carry = s[16]; m_zero = (m_acc == 16'h0); end
            4'd3: begin m_carry = (m_acc < b); m_acc = m_acc - b; m_zero = (m_acc == 16'h0); end
            4'd4: begin
                p = 32'(m_acc) * 32'(b);
                m_acc = p[15:0]; m_carry = (p[31:16] != 16'h0); m_zero = (m_acc == 16'h0); e.lat = 16;
            end
            4'd5: begin
                if (b == 16'h0) begin
                    m_err = 1'b1;
                end else begin
                    m_rem = m_acc % b; m_acc = m_acc / b; m_carry = 1'b0; m_zero = (m_acc == 16'h0); e.lat = 16;
                end
            end
            4'd6: begin m_acc = m_acc & b; m_carry = 1'b0; m_zero = (m_acc == 16'h0); end
            4'd7: begin m_acc = m_acc | b; m_carry = 1'b0; m_zero = (m_acc == 16'h0); end
            4'd8: begin m_acc = ~m_acc;    m_carry = 1'b0; m_zero = (m_acc == 16'h0); end
            4'd9: begin m_acc = m_acc ^ b; m_carry = 1'b0; m_zero = (m_acc == 16'h0); end
            default: m_err = 1'b1;
        endcase
        e.acc = m_acc; e.rem = m_rem; e.carry = m_carry; e.zero = m_zero; e.err = m_err;
        sb.push_back(e);
    endtask

    // Pop the oldest expected result and compare it against the DUT outputs.
    task automatic pop_cmp(input string tag, output int lat);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            lat = -1;
        end else begin
            e   = sb.pop_front();
            lat = e.lat;
            chk({tag, "_acc"},   32'(acc),   32'(e.acc));
            chk({tag, "_rem"},   32'(rem),   32'(e.rem));
            chk({tag, "_carry"}, 32'(carry), 32'(e.carry));
            chk({tag, "_zero"},  32'(zero),  32'(e.zero));
            chk({tag, "_err"},   32'(err),   32'(e.err));
        end
    endtask

    // Issue one command, wait (bounded) for done, then check result and latency.
    task automatic send(input logic [3:0] op, input logic [W-1:0] b, input string tag);
        int           n;
        int           lat;
        logic [W-1:0] pre_acc;
        @(negedge clk);
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        opcode    = op;
        operand   = b;
        @(posedge clk);
        pre_acc = m_acc;
        model_push(op, b);
        #1;
        cmd_valid = 1'b0;
        opcode    = 4'd0;
        operand   = 16'h0;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            if (n == 4) begin
                chk({tag, "_busy_ready"}, 32'(cmd_ready), 32'd0);
                chk({tag, "_busy_acc"},   32'(acc),       32'(pre_acc));
            end
            @(posedge clk);
            #1;
            n++;
        end
        pop_cmp(tag, lat);
        chk({tag, "_latency"}, 32'(n), 32'(lat));
        chk({tag, "_done_ready"}, 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        opcode    = 4'd0;
        operand   = 16'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_acc",   32'(acc),       32'h0);
        chk("rst_rem",   32'(rem),       32'h0);
        chk("rst_carry", 32'(carry),     32'd0);
        chk("rst_zero",  32'(zero),      32'd1);
        chk("rst_err",   32'(err),       32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back single-cycle ADDs: done on consecutive cycles.
        @(negedge clk);
        cmd_valid = 1'b1; opcode = 4'd2; operand = 16'h0005;
        @(posedge clk);
        model_push(4'd2, 16'h0005);
        #1;
        chk("b2b_done0", 32'(done), 32'd1);
        pop_cmp("b2b_add5", lat);
        opcode = 4'd2; operand = 16'hFFFC;
        @(posedge clk);
        model_push(4'd2, 16'hFFFC);
        #1;
        cmd_valid = 1'b0;
        chk("b2b_done1", 32'(done), 32'd1);
        pop_cmp("b2b_addfffc", lat);
        @(posedge clk);
        #1;
        chk("b2b_done_end", 32'(done), 32'd0);

        // SUB borrow, then AND clears carry.
        send(4'd1, 16'h0000, "reset_op");
        send(4'd2, 16'h0001, "set1");
        send(4'd3, 16'h0003, "sub3");
        send(4'd6, 16'h00F0, "and_f0");
        send(4'd7, 16'h0F0F, "or");
        send(4'd9, 16'hFFFF, "xor");
        send(4'd0, 16'h1234, "noop");

        // MULT overflow then a small product.
        send(4'd1, 16'h0000, "reset_op2");
        send(4'd2, 16'h0100, "set100");
        send(4'd4, 16'h0100, "mult_ovf");
        send(4'd2, 16'h0003, "add3");
        send(4'd4, 16'h0007, "mult7");
        send(4'd4, 16'hFFFF, "mult_ffff");

        // DIV and divide-by-zero.
        send(4'd1, 16'h0000, "reset_op3");
        send(4'd2, 16'd100,  "set100d");
        send(4'd5, 16'd7,    "div7");
        send(4'd5, 16'd0,    "div0");
        send(4'd5, 16'd20,   "div_small");

        // Illegal opcode, NOT, RESET.
        send(4'hC, 16'h0000, "illegal");
        send(4'd1, 16'h0000, "reset_op4");
        send(4'd2, 16'h00FF, "setff");
        send(4'd8, 16'hAAAA, "not");
        send(4'd1, 16'h0000, "reset_op5");

        // MULT aborted by rst with cmd_valid held high throughout.
        send(4'd2, 16'h0003, "pre_abort");
        @(negedge clk);
        cmd_valid = 1'b1; opcode = 4'd4; operand = 16'h0005;
        @(posedge clk);
        #1;
        chk("abort_busy", 32'(cmd_ready), 32'd0);
        opcode = 4'd2; operand = 16'h0001;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", 32'(done), 32'd0);
            chk("abort_acc_held", 32'(acc), 32'h0003);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        chk("abort_acc",   32'(acc),       32'h0);
        chk("abort_zero",  32'(zero),      32'd1);
        chk("abort_done",  32'(done),      32'd0);
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        model_push(4'd2, 16'h0001);
        #1;
        cmd_valid = 1'b0;
        chk("post_abort_done", 32'(done), 32'd1);
        pop_cmp("post_abort_add", lat);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("post_abort_quiet", 32'(done), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
